pow2_signed_divider_pipe: RTL and testbench
===========================================

Name: pow2_signed_divider_pipe

Overview:
Pipelined, parametrised signed divide-by-power-of-two unit with a run-time shift amount and per-transaction rounding mode.
- MODE_FLOOR: arithmetic right shift, rounds toward minus infinity.
- MODE_TRUNC: true signed division, rounds toward zero.
- Valid/ready streaming block inside the arithmetic datapath.
- Supersedes the fixed-shift combinational shifters.
- Shift is built as a log-depth barrel shifter, one register stage per shift-amount bit.

Parameters:
N, 8, data width in bits (N >= 2)
SHW, $clog2(N)+1, width of the shift-amount port; covers 0..2^SHW-1, including values >= N

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
up_valid  input  1  input transaction valid
up_ready  output  1  block accepts input this cycle
up_data  input  N  signed dividend
up_shift  input  SHW  shift amount s (divisor 2^s)
up_mode  input  1  0 = MODE_FLOOR, 1 = MODE_TRUNC
down_valid  output  1  result valid
down_ready  input  1  consumer accepts result
down_data  output  N  signed quotient

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst), sampled on rising clk.
- Reset values:
  - all stage valid bits = 0, so down_valid = 0.
  - down_data = 0.
  - data and shift registers are don't-care except down_data.
- Pipeline is SHW+1 stages:
  - Stage 0 (bias): if mode == TRUNC and data < 0, add bias = 2^min(s,N-1) - 1, then register.
    - For s <= N-1 this cannot overflow N bits.
    - Bias is skipped when s >= N; see saturation below.
  - Stage k+1, k = 0..SHW-1: if shift bit k is set, arithmetic-shift right by 2^k with sign fill, then register.
    - Shift by 2^k >= N yields all sign bits.
- Latency is SHW+1 cycles from accepted input to down_valid, when down_ready is held 1. Throughput is 1 per cycle.
- Saturation, s >= N:
  - FLOOR gives -1 for negative input, 0 otherwise.
  - TRUNC gives 0.
- s = 0 passes data unchanged in both modes.
- Handshake:
  - Global advance enable en = down_ready | ~down_valid.
  - up_ready = en, combinational from down_ready and down_valid.
  - All stages advance together when en = 1; all hold when en = 0.
  - Bubbles (valid = 0) propagate but do not self-compress.
- Transfer rules:
  - An input is accepted when up_valid & up_ready.
  - An output is consumed when down_valid & down_ready.
  - Both may occur in the same cycle.
- down_data and down_valid must stay stable while down_valid & ~down_ready.
- Reset mid-stream discards all in-flight transactions; down_valid = 0 the cycle after rst.
- Values of N other than a power of two must work; unused shift codes fall under saturation.

Optional Feature:
Macro POW2_DIV_INEXACT_EN.
- Defined:
  - Adds output port down_inexact (1 bit), aligned with down_data.
  - down_inexact = 1 iff any bit shifted out of the original dividend was 1, i.e. the result is not exact.
  - Computed from the unbiased input.
  - Stage logic ORs the lost bits into a per-stage sticky register.
  - Reset value 0.
- Not defined: port and sticky registers are absent; all other behaviour is identical.

Decomposition:
- Package pow2_div_pkg holds:
  - typedef enum logic {MODE_FLOOR = 1'b0, MODE_TRUNC = 1'b1} div_mode_t;
  - a localparam helper function returning the per-stage shift 2^k.
- Sub-module pow2_div_shift_stage, parametrised by N and stage index K, contains:
  - a conditional arithmetic shift by 2^K;
  - valid, data, remaining-shift and (optional) sticky registers with enable en.
  - The top level instantiates it SHW times in a generate loop after the bias stage.

Test Plan:
- N=8, down_ready=1: a=-7 (0xF9), s=1, FLOOR -> 0xFC (-4); TRUNC -> 0xFD (-3); each appears 5 cycles after acceptance.
- a=100, s=3 -> 12 in both modes; a=-128, s=7 -> -1 both modes; a=-1, s=8, FLOOR -> 0xFF, TRUNC -> 0x00; s=15 same.
- Back-to-back 10 random inputs, random s and mode, down_ready=1 -> one result per cycle, in order, matching the reference model (>>> for FLOOR, / for TRUNC).
- Backpressure: feed 3 inputs, then hold down_ready=0 for 6 cycles.
  - Expect up_ready=0 while down_valid & ~down_ready, and down_data stable.
  - On release, all 3 results arrive in order with none lost or duplicated.
- Assert rst for 1 cycle with 4 transactions in flight -> down_valid=0 next cycle, no stale output afterwards.
- With POW2_DIV_INEXACT_EN: a=-8, s=3 -> down_inexact=0; a=-7, s=1 -> down_inexact=1; s=0 -> always 0.

Source files
------------

// File: rtl/pow2_div_pkg.sv
// Shared types and helpers for the power-of-two signed divider pipeline.
package pow2_div_pkg;

  typedef enum logic {MODE_FLOOR = 1'b0, MODE_TRUNC = 1'b1} div_mode_t;

  // Constant right-shift distance applied by shift stage k.
  function automatic int stage_shift(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/pow2_div_shift_stage.sv
// One barrel-shifter stage: conditional arithmetic right shift by 2^K, registered.
// Sticky ports exist only when POW2_DIV_INEXACT_EN is defined.
module pow2_div_shift_stage
  import pow2_div_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = 4,
  parameter int K   = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_valid,
  input  logic [N-1:0]   i_data,
  input  logic [SHW-1:0] i_shift,
  output logic           o_valid,
  output logic [N-1:0]   o_data,
  output logic [SHW-1:0] o_shift
`ifdef POW2_DIV_INEXACT_EN
  ,
  input  logic           i_sticky,
  output logic           o_sticky
`endif
);

  localparam int SH = stage_shift(K);

  logic           r_valid;
  logic [N-1:0]   r_data;
  logic [SHW-1:0] r_shift;
  logic [N-1:0]   w_shifted;
  logic [N-1:0]   w_next;

  // A distance of N or more leaves nothing but sign bits.
  generate
    if (SH >= N) begin : g_fill
      assign w_shifted = {N{i_data[N-1]}};
    end else begin : g_shift
      assign w_shifted = $signed(i_data) >>> SH;
    end
  endgenerate

  assign w_next = i_shift[K] ? w_shifted : i_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_next;
      r_shift <= i_shift;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shift = r_shift;

`ifdef POW2_DIV_INEXACT_EN
  // Inexactness is fully resolved at the bias stage; each stage keeps it aligned.
  logic r_sticky;

  always_ff @(posedge clk) begin
    if (rst)       r_sticky <= 1'b0;
    else if (i_en) r_sticky <= i_sticky;
  end

  assign o_sticky = r_sticky;
`endif

endmodule

// File: rtl/pow2_signed_divider_pipe.sv
// Pipelined signed divide by 2^s: bias stage, then SHW barrel-shift stages.
// Define POW2_DIV_INEXACT_EN to add the down_inexact output.
module pow2_signed_divider_pipe
  import pow2_div_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up_valid,
  output logic           up_ready,
  input  logic [N-1:0]   up_data,
  input  logic [SHW-1:0] up_shift,
  input  logic           up_mode,
  output logic           down_valid,
  input  logic           down_ready,
  output logic [N-1:0]   down_data
`ifdef POW2_DIV_INEXACT_EN
  ,
  output logic           down_inexact
`endif
);

  localparam logic [SHW-1:0] L_N   = SHW'(N);
  localparam logic [SHW-1:0] L_NM1 = SHW'(N - 1);
  localparam logic [N-1:0]   L_ONE = N'(1);

  logic                      w_en;
  logic [SHW:0]              w_valid;
  logic [SHW:0][N-1:0]       w_data;
  logic [SHW:0][SHW-1:0]     w_shift;

  // Whole pipe moves in lockstep; it only stalls when the output is held.
  assign w_en     = down_ready | ~down_valid;
  assign up_ready = w_en;

  logic           w_trunc;
  logic           w_sat;
  logic [SHW-1:0] w_bias_sh;
  logic [N-1:0]   w_bias;
  logic [N-1:0]   w_data0;

  assign w_trunc   = (div_mode_t'(up_mode) == MODE_TRUNC);
  assign w_sat     = (up_shift >= L_N);
  assign w_bias_sh = w_sat ? L_NM1 : up_shift;
  assign w_bias    = (L_ONE << w_bias_sh) - L_ONE;

  // Saturated TRUNC is zeroed here so the sign fill downstream cannot produce -1.
  always_comb begin
    w_data0 = up_data;
    if (w_trunc && w_sat)              w_data0 = '0;
    else if (w_trunc && up_data[N-1])  w_data0 = up_data + w_bias;
  end

  logic           r_valid0;
  logic [N-1:0]   r_data0;
  logic [SHW-1:0] r_shift0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid0 <= 1'b0;
      r_data0  <= '0;
      r_shift0 <= '0;
    end else if (w_en) begin
      r_valid0 <= up_valid;
      r_data0  <= w_data0;
      r_shift0 <= up_shift;
    end
  end

  assign w_valid[0] = r_valid0;
  assign w_data[0]  = r_data0;
  assign w_shift[0] = r_shift0;

`ifdef POW2_DIV_INEXACT_EN
  logic [SHW:0] w_sticky;
  logic [N-1:0] w_mask;
  logic         r_sticky0;

  // Lost bits are the low min(s,N) bits of the unbiased dividend.
  assign w_mask = w_sat ? '1 : ((L_ONE << up_shift) - L_ONE);

  always_ff @(posedge clk) begin
    if (rst)       r_sticky0 <= 1'b0;
    else if (w_en) r_sticky0 <= |(up_data & w_mask);
  end

  assign w_sticky[0]  = r_sticky0;
  assign down_inexact = w_sticky[SHW];
`endif

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      pow2_div_shift_stage #(.N(N), .SHW(SHW), .K(k)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_valid (w_valid[k]),
        .i_data  (w_data[k]),
        .i_shift (w_shift[k]),
        .o_valid (w_valid[k+1]),
        .o_data  (w_data[k+1]),
        .o_shift (w_shift[k+1])
`ifdef POW2_DIV_INEXACT_EN
        ,
        .i_sticky(w_sticky[k]),
        .o_sticky(w_sticky[k+1])
`endif
      );
    end
  endgenerate

  logic w_unused;
  assign w_unused = ^w_shift[SHW];

  assign down_valid = w_valid[SHW];
  assign down_data  = w_data[SHW];

endmodule

// File: tb/tb_pow2_signed_divider_pipe.sv
// Randomized and directed bench for pow2_signed_divider_pipe against an arithmetic reference.
module tb_pow2_signed_divider_pipe;

  localparam int N   = 8;
  localparam int SHW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           up_valid;
  logic           up_ready;
  logic [N-1:0]   up_data;
  logic [SHW-1:0] up_shift;
  logic           up_mode;
  logic           down_valid;
  logic           down_ready;
  logic [N-1:0]   down_data;
`ifdef POW2_DIV_INEXACT_EN
  logic           down_inexact;
`endif

  pow2_signed_divider_pipe #(.N(N), .SHW(SHW)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_shift   (up_shift),
    .up_mode    (up_mode),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
`ifdef POW2_DIV_INEXACT_EN
    ,
    .down_inexact(down_inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic         inx;
    int           stamp;
  } exp_t;

  exp_t         sb[$];
  int           ntests = 0;
  int           nfail  = 0;
  int           cnt    = 0;
  bit           chk_lat = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data;

  // Quotient a / 2^s from plain integer arithmetic.
  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input int s, input logic m);
    int ai, dv, q;
    ai = int'($signed(a));
    dv = 1 << s;
    q  = ai / dv;
    if (!m && (ai % dv != 0) && ai < 0) q = q - 1;
    return q[N-1:0];
  endfunction

  function automatic logic ref_inx(input logic [N-1:0] a, input int s);
    int ai;
    ai = int'($signed(a));
    return ((ai % (1 << s)) != 0);
  endfunction

  task automatic cyc(input logic v, input logic [N-1:0] d, input logic [SHW-1:0] s,
                     input logic m, input logic dr);
    exp_t e;
    up_valid = v; up_data = d; up_shift = s; up_mode = m; down_ready = dr;
    @(negedge clk);
    ntests++;
    assert (up_ready === (down_ready | ~down_valid))
      else begin nfail++; $error("FAIL up_ready obs=%b exp=%b", up_ready, down_ready | ~down_valid); end
    if (prev_stall) begin
      ntests++;
      assert (down_valid === 1'b1 && down_data === prev_data)
        else begin nfail++; $error("FAIL stall_hold obs=%b/%h exp=1/%h", down_valid, down_data, prev_data); end
    end
    prev_stall = down_valid & ~down_ready;
    prev_data  = down_data;
    if (down_valid && down_ready) begin
      ntests++;
      assert (sb.size() > 0)
        else begin nfail++; $error("FAIL stale_out obs=%h exp=no_output", down_data); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ntests++;
        assert (down_data === e.q)
          else begin nfail++; $error("FAIL data obs=%h exp=%h", down_data, e.q); end
`ifdef POW2_DIV_INEXACT_EN
        ntests++;
        assert (down_inexact === e.inx)
          else begin nfail++; $error("FAIL inexact obs=%b exp=%b", down_inexact, e.inx); end
`endif
        if (chk_lat) begin
          ntests++;
          assert (cnt - e.stamp == SHW + 1)
            else begin nfail++; $error("FAIL latency obs=%0d exp=%0d", cnt - e.stamp, SHW + 1); end
        end
      end
    end
    if (up_valid && up_ready) begin
      e.q = ref_q(d, int'(s), m);
      e.inx = ref_inx(d, int'(s));
      e.stamp = cnt;
      sb.push_back(e);
    end
    @(posedge clk); #1; cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    ntests++;
    assert (sb.size() == 0)
      else begin nfail++; $error("FAIL drain obs=%0d_pending exp=0_pending", sb.size()); end
  endtask

  task automatic do_reset();
    rst = 1'b1; up_valid = 1'b0; down_ready = 1'b1;
    @(posedge clk); #1; cnt++;
    rst = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    ntests++;
    assert (down_valid === 1'b0)
      else begin nfail++; $error("FAIL rst_valid obs=%b exp=0", down_valid); end
    ntests++;
    assert (down_data === '0)
      else begin nfail++; $error("FAIL rst_data obs=%h exp=00", down_data); end
`ifdef POW2_DIV_INEXACT_EN
    ntests++;
    assert (down_inexact === 1'b0)
      else begin nfail++; $error("FAIL rst_inexact obs=%b exp=0", down_inexact); end
`endif
    @(posedge clk); #1; cnt++;
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_data = '0; up_shift = '0; up_mode = 1'b0; down_ready = 1'b1;
    do_reset();

    // Directed single transactions with latency checking.
    chk_lat = 1'b1;
    cyc(1'b1, 8'hF9, 4'd1, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'hF9, 4'd1, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'd100, 4'd3, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'd100, 4'd3, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'h80, 4'd7, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'h80, 4'd7, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'hFF, 4'd8, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'hFF, 4'd8, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'hFF, 4'd15, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'hFF, 4'd15, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'hF8, 4'd3, 1'b0, 1'b1); drain();
    cyc(1'b1, 8'hA5, 4'd0, 1'b1, 1'b1); drain();
    cyc(1'b1, 8'h7F, 4'd9, 1'b0, 1'b1); drain();

    // Back-to-back random stream, output always ready.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, N'($urandom), SHW'($urandom), 1'($urandom), 1'b1);
    drain();

    // Backpressure: three in, then hold the consumer off.
    chk_lat = 1'b0;
    cyc(1'b1, 8'h9C, 4'd2, 1'b1, 1'b1);
    cyc(1'b1, 8'h37, 4'd1, 1'b0, 1'b1);
    cyc(1'b1, 8'hC1, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    drain();

    // Reset with four transactions in flight; nothing may emerge afterwards.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, N'($urandom), SHW'($urandom), 1'($urandom), 1'b1);
    do_reset();
    idle(10);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom), N'($urandom), SHW'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
